// File: rtl/wb_b3_pkg.sv
// ---------------------------------------------------------------------------
// wb_b3_pkg
//
// Shared Wishbone B3 definitions for the burst read master:
//   - cycle type identifier (CTI) codes for classic, incrementing burst and
//     end-of-burst beats
//   - burst type extension (BTE) code for linear bursts
//   - the read-master state type
//   - a helper that sizes the next burst from the outstanding word count
// ---------------------------------------------------------------------------
package wb_b3_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PLAN   = 2'd1,
        ST_BURST  = 2'd2,
        ST_FINISH = 2'd3
    } rd_state_e;

    // Next burst length: whatever is left, capped at the burst limit.
    function automatic logic [15:0] burstBeats(input logic [15:0] remaining,
                                               input logic [15:0] maxBurst);
        return (remaining < maxBurst) ? remaining : maxBurst;
    endfunction

endpackage

// File: rtl/wb_rd_fifo.sv
// ---------------------------------------------------------------------------
// wb_rd_fifo
//
// Synchronous first-word-fall-through FIFO holding read data returned by the
// Wishbone bus. A word pushed at a clock edge is presented on o_data with
// o_empty low right after that edge. Push and pop may happen together in the
// same cycle, including when the FIFO is full (the pop frees the slot the
// push fills) or empty (the pop is ignored, the push lands).
//
// Ports:
//   clk          - clock, rising edge
//   rst_n        - synchronous active-low reset, empties the FIFO
//   i_push       - write i_data this cycle
//   i_data       - write data
//   i_pop        - consume the head word this cycle
//   o_data       - head word (valid while o_empty is low)
//   o_full       - no free entries
//   o_empty      - no stored entries
//   o_freeCount  - number of free entries (0..DEPTH)
// ---------------------------------------------------------------------------
module wb_rd_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_freeCount
);

    localparam int PW    = $clog2(DEPTH);
    localparam int CNT_W = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wrPtr;
    logic [PW-1:0]    r_rdPtr;
    logic [CNT_W-1:0] r_count;

    logic w_doPush;
    logic w_doPop;

    // A pop only happens when there is something to pop; a push is allowed
    // when there is room or when a simultaneous pop makes room.
    assign w_doPop  = i_pop && !o_empty;
    assign w_doPush = i_push && (!o_full || w_doPop);

    assign o_empty     = (r_count == '0);
    assign o_full      = (r_count == CNT_W'(DEPTH));
    assign o_freeCount = CNT_W'(DEPTH) - r_count;
    assign o_data      = r_mem[r_rdPtr];

    // Storage array is left out of reset so it maps onto plain RAM; the
    // occupancy count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; the count
    // tracks occupancy so full and empty are unambiguous.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + PW'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + PW'(1);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/wb_b3_burst_reader.sv
// ---------------------------------------------------------------------------
// wb_b3_burst_reader
//
// Wishbone B3 read master. A command (start byte address + word count) is
// split into linear incrementing bursts of at most MAX_BURST beats. Each
// burst is only started once the read-data FIFO has room for all of its
// beats, so the bus never has to be stalled to avoid an overflow. Returned
// words stream out through a first-word-fall-through FIFO that drains
// independently of the command state.
//
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   cmd_valid/cmd_ready - command handshake (ready only while idle)
//   cmd_addr            - word-aligned byte start address
//   cmd_len             - number of 32-bit words to read (0 allowed)
//   wb_*_o              - Wishbone B3 master outputs (read-only bursts)
//   wb_ack_i/wb_err_i   - slave termination, err wins over ack
//   wb_dat_i            - slave read data
//   dout_data/valid/ready - read-data stream
//   busy                - command in progress
//   done                - one-cycle pulse when a command completes
//   err                 - sticky bus-error flag, cleared by the next command
// ---------------------------------------------------------------------------
module wb_b3_burst_reader
    import wb_b3_pkg::*;
#(
    parameter int AW         = 32,
    parameter int MAX_BURST  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_addr,
    input  logic [15:0]   cmd_len,

    output logic [AW-1:0] wb_adr_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic          wb_we_o,
    output logic [3:0]    wb_sel_o,
    output logic [31:0]   wb_dat_o,
    output logic [2:0]    wb_cti_o,
    output logic [1:0]    wb_bte_o,
    input  logic          wb_ack_i,
    input  logic          wb_err_i,
    input  logic [31:0]   wb_dat_i,

    output logic [31:0]   dout_data,
    output logic          dout_valid,
    input  logic          dout_ready,

    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int BW = $clog2(MAX_BURST) + 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    rd_state_e      r_state;
    logic [AW-1:0]  r_adr;
    logic           r_cyc;
    logic [2:0]     r_cti;
    logic [15:0]    r_remaining;
    logic [BW-1:0]  r_beatsLeft;
    logic           r_done;
    logic           r_err;

    logic [15:0]    w_planBeats;
    logic           w_planFits;
    logic           w_ackEvent;
    logic           w_errEvent;
    logic           w_fifoPush;
    logic           w_fifoPop;
    logic           w_fifoFull;
    logic           w_fifoEmpty;
    logic [CW-1:0]  w_fifoFree;

    // Terminations only count while a cycle is open; an error wins over a
    // simultaneous ack and then stores no data.
    assign w_errEvent = r_cyc && wb_err_i;
    assign w_ackEvent = r_cyc && wb_ack_i && !wb_err_i;

    // A burst is admitted only if every one of its beats already has a FIFO
    // slot reserved, which is what lets the bus run without wait states.
    assign w_planBeats = burstBeats(r_remaining, 16'(MAX_BURST));
    assign w_planFits  = !w_fifoFull &&
                         ({{(16-CW){1'b0}}, w_fifoFree} >= w_planBeats);

    assign w_fifoPush = (r_state == ST_BURST) && w_ackEvent;
    assign w_fifoPop  = dout_valid && dout_ready;

    wb_rd_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_fifoPush),
        .i_data      (wb_dat_i),
        .i_pop       (w_fifoPop),
        .o_data      (dout_data),
        .o_full      (w_fifoFull),
        .o_empty     (w_fifoEmpty),
        .o_freeCount (w_fifoFree)
    );

    assign dout_valid = !w_fifoEmpty;

    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign err       = r_err;

    assign wb_adr_o  = r_adr;
    assign wb_cyc_o  = r_cyc;
    assign wb_stb_o  = r_cyc;
    assign wb_cti_o  = r_cti;
    assign wb_we_o   = 1'b0;
    assign wb_sel_o  = 4'hF;
    assign wb_dat_o  = 32'h0;
    assign wb_bte_o  = BTE_LINEAR;

    // Command sequencer. IDLE latches the command, PLAN sizes the next burst
    // and waits for FIFO room, BURST keeps cyc/stb up until the last beat
    // (or an error) terminates, FINISH raises done for one cycle. The bus
    // address advances after every ack, so at the end of a burst it already
    // points at the first word of the next one. CTI is precomputed one beat
    // ahead so the final beat of every burst carries end-of-burst.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_adr       <= '0;
            r_cyc       <= 1'b0;
            r_cti       <= CTI_CLASSIC;
            r_remaining <= '0;
            r_beatsLeft <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_adr       <= cmd_addr;
                        r_remaining <= cmd_len;
                        r_err       <= 1'b0;
                        r_state     <= (cmd_len == 16'd0) ? ST_FINISH : ST_PLAN;
                    end
                end
                ST_PLAN: begin
                    if (w_planFits) begin
                        r_cyc       <= 1'b1;
                        r_cti       <= (w_planBeats == 16'd1) ? CTI_EOB : CTI_INCR;
                        r_beatsLeft <= BW'(w_planBeats);
                        r_state     <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (w_errEvent) begin
                        r_cyc       <= 1'b0;
                        r_cti       <= CTI_CLASSIC;
                        r_err       <= 1'b1;
                        r_remaining <= '0;
                        r_state     <= ST_FINISH;
                    end else if (w_ackEvent) begin
                        r_adr       <= r_adr + AW'(4);
                        r_remaining <= r_remaining - 16'd1;
                        r_beatsLeft <= r_beatsLeft - BW'(1);
                        if (r_beatsLeft == BW'(1)) begin
                            r_cyc   <= 1'b0;
                            r_cti   <= CTI_CLASSIC;
                            r_state <= (r_remaining == 16'd1) ? ST_FINISH : ST_PLAN;
                        end else begin
                            r_cti   <= (r_beatsLeft == BW'(2)) ? CTI_EOB : CTI_INCR;
                        end
                    end
                end
                ST_FINISH: begin
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_b3_burst_reader.sv
// ---------------------------------------------------------------------------
// tb_wb_b3_burst_reader
//
// Self-checking bench. Commands are issued by applyStimulus, which also
// pushes the expected bus beats and read words (derived from the command
// arithmetic) into scoreboards. A Wishbone slave process answers beats and
// checks address/CTI as they appear; a stream monitor pops expected words
// whenever the DUT hands one out.
// ---------------------------------------------------------------------------
module tb_wb_b3_burst_reader;

    typedef struct packed {
        logic [31:0] adr;
        logic [2:0]  cti;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_len;
    logic [31:0] wb_adr_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic [31:0] wb_dat_i;
    logic [31:0] dout_data;
    logic        dout_valid;
    logic        dout_ready;
    logic        busy;
    logic        done;
    logic        err;

    int    nChecks = 0;
    int    nFails  = 0;
    int    cycle   = 0;
    beat_t busQ[$];
    logic [31:0] dataQ[$];

    bit    zeroWait    = 1;
    bit    noiseOn     = 0;
    bit    pendingDrop = 0;
    bit    cycSeen     = 0;
    int    cmdBeats    = 0;
    int    errBeatIdx  = -1;
    int    readyMode   = 1;
    int    drainLeft   = 0;
    int    doneCount   = 0;
    int    doneBefore  = 0;
    int    acceptCycle = 0;
    int    lastDoneCycle = 0;

    wb_b3_burst_reader #(
        .AW         (32),
        .MAX_BURST  (8),
        .FIFO_DEPTH (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .wb_adr_o   (wb_adr_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_sel_o   (wb_sel_o),
        .wb_dat_o   (wb_dat_o),
        .wb_cti_o   (wb_cti_o),
        .wb_bte_o   (wb_bte_o),
        .wb_ack_i   (wb_ack_i),
        .wb_err_i   (wb_err_i),
        .wb_dat_i   (wb_dat_i),
        .dout_data  (dout_data),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // 100 MHz-style free-running clock and a cycle counter for latency checks.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cycle++;
        end
    end

    // Hard stop so a hung DUT still produces a verdict.
    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required finish before it");
        $fatal(1, "[TB] watchdog expired");
    end

    // Contents of the simulated slave memory: a fixed scramble of the address.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16]} + 32'h1357_9BDF;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)",
                     name, actual, expected, cycle);
        end
    endtask

    task automatic reportFail(input string name, input string info);
        nChecks++;
        nFails++;
        $display("[TB] FAIL %s: %s (cycle %0d)", name, info, cycle);
    endtask

    // Reference model: split len words into bursts of up to 8, each beat's
    // address is start + 4*index mod 2^32, the last beat of a burst is EOB.
    // A bus error at beat errBeat ends the command; only earlier words arrive.
    task automatic pushModel(input logic [31:0] addr, input int len,
                             input int errBeat);
        int rem = len;
        int idx = 0;
        bit stop = 0;
        while (rem > 0 && !stop) begin
            int b = (rem < 8) ? rem : 8;
            for (int j = 0; j < b && !stop; j++) begin
                logic [31:0] a;
                beat_t bt;
                a = addr + 32'(idx) * 32'd4;
                bt.adr = a;
                bt.cti = (j == b - 1) ? 3'b111 : 3'b010;
                busQ.push_back(bt);
                if (idx == errBeat) stop = 1;
                else dataQ.push_back(memWord(a));
                idx++;
            end
            rem -= b;
        end
    endtask

    // Wishbone slave plus bus checker, evaluated on the falling edge.
    initial begin
        beat_t expBeat;
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = 32'h0;
        forever begin
            @(negedge clk);
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            wb_dat_i = 32'h0;
            if (pendingDrop) begin
                checkOutput("cycDropAfterLastBeat", 32'(wb_cyc_o), 32'd0);
                pendingDrop = 0;
            end
            if (rst_n && wb_cyc_o) begin
                cycSeen = 1;
                checkOutput("busStaticSignals",
                            {23'd0, wb_stb_o, wb_we_o, wb_sel_o, wb_bte_o, |wb_dat_o},
                            {23'd0, 9'b1_0_1111_00_0});
                if (zeroWait || $urandom_range(0, 2) != 0) begin
                    if (busQ.size() == 0) begin
                        reportFail("unexpectedBeat", $sformatf("beat at 0x%08h, required none", wb_adr_o));
                        expBeat.adr = wb_adr_o;
                        expBeat.cti = 3'b111;
                    end else begin
                        expBeat = busQ.pop_front();
                        checkOutput("busAdr", wb_adr_o, expBeat.adr);
                        checkOutput("busCti", 32'(wb_cti_o), 32'(expBeat.cti));
                    end
                    if (cmdBeats == errBeatIdx) begin
                        wb_err_i = 1'b1;
                        wb_ack_i = $urandom_range(0, 1) == 1;
                    end else begin
                        wb_ack_i = 1'b1;
                        wb_dat_i = memWord(wb_adr_o);
                    end
                    if (wb_err_i || expBeat.cti == 3'b111) pendingDrop = 1;
                    cmdBeats++;
                end
            end else if (noiseOn) begin
                wb_ack_i = $urandom_range(0, 1) == 1;
                wb_err_i = $urandom_range(0, 3) == 0;
                wb_dat_i = $urandom;
            end
        end
    end

    // Read-data stream monitor: pops the scoreboard on each transfer and
    // checks that a stalled word stays put.
    initial begin
        bit holdPending = 0;
        logic [31:0] heldData = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                holdPending = 0;
            end else begin
                if (holdPending) begin
                    checkOutput("doutHoldValid", 32'(dout_valid), 32'd1);
                    checkOutput("doutHoldData", dout_data, heldData);
                end
                if (dout_valid && dout_ready) begin
                    if (dataQ.size() == 0)
                        reportFail("unexpectedWord", $sformatf("got 0x%08h, required none", dout_data));
                    else
                        checkOutput("doutData", dout_data, dataQ.pop_front());
                end
                holdPending = dout_valid && !dout_ready;
                heldData    = dout_data;
            end
        end
    end

    // done monitor: counts pulses and checks each lasts a single cycle.
    initial begin
        bit prevDone = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prevDone = 0;
            end else begin
                if (done) begin
                    checkOutput("doneSingleCycle", 32'(prevDone), 32'd0);
                    doneCount++;
                    lastDoneCycle = cycle;
                end
                prevDone = done;
            end
        end
    end

    // dout_ready driver: 0 = hold, 1 = always, 2 = random, 3 = drainLeft pops.
    initial begin
        dout_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                1: dout_ready = 1'b1;
                2: dout_ready = $urandom_range(0, 1) == 1;
                3: begin
                    if (drainLeft > 0) begin
                        dout_ready = 1'b1;
                        drainLeft--;
                    end else begin
                        dout_ready = 1'b0;
                    end
                end
                default: dout_ready = 1'b0;
            endcase
        end
    end

    task automatic applyStimulus(input logic [31:0] addr, input int len,
                                 input int errBeat);
        bit accepted = 0;
        cmdBeats   = 0;
        errBeatIdx = errBeat;
        cycSeen    = 0;
        pushModel(addr, len, errBeat);
        @(posedge clk);
        #1;
        cmd_addr  = addr;
        cmd_len   = 16'(len);
        cmd_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                accepted    = 1;
                acceptCycle = cycle;
                doneBefore  = doneCount;
                break;
            end
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        if (!accepted) reportFail("cmdAccept", "cmd_ready never seen, required within 100 cycles");
        checkOutput("errClearOnAccept", 32'(err), 32'd0);
        checkOutput("busyAfterAccept", 32'(busy), 32'd1);
    endtask

    task automatic waitDone(input bit expErr);
        bit found = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) begin
                found = 1;
                break;
            end
        end
        if (!found) begin
            reportFail("doneTimeout", "done not seen, required within 3000 cycles");
        end else begin
            checkOutput("errAtDone", 32'(err), 32'(expErr));
            checkOutput("idleAtDone", {30'd0, busy, cmd_ready}, 32'b01);
        end
        repeat (3) @(negedge clk);
        checkOutput("doneOnce", 32'(doneCount - doneBefore), 32'd1);
    endtask

    task automatic drainAll();
        readyMode = 1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (dataQ.size() == 0 && !dout_valid) break;
        end
        @(negedge clk);
        checkOutput("drainedWords", 32'(dataQ.size()), 32'd0);
        checkOutput("fifoEmptyAfterDrain", 32'(dout_valid), 32'd0);
        checkOutput("allBeatsSeen", 32'(busQ.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] rAddr;
        int rLen;
        int rErr;
        int beatsAtReset;
        bit seen;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = 32'h0;
        cmd_len   = 16'h0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("resetCyc", 32'(wb_cyc_o), 32'd0);
        checkOutput("resetStb", 32'(wb_stb_o), 32'd0);
        checkOutput("resetCti", 32'(wb_cti_o), 32'd0);
        checkOutput("resetAdr", wb_adr_o, 32'h0);
        checkOutput("resetStatus", {28'd0, dout_valid, busy, done, err}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("cmdReadyAfterReset", 32'(cmd_ready), 32'd1);

        // Single short burst with a zero-wait slave.
        $display("[TB] basic len=3 burst at 0x1000");
        zeroWait  = 1;
        readyMode = 1;
        applyStimulus(32'h0000_1000, 3, -1);
        waitDone(0);
        drainAll();

        // FIFO back-pressure: third burst must wait for 4 free slots.
        $display("[TB] len=20 with stalled consumer");
        readyMode = 0;
        rAddr = $urandom;
        rAddr[1:0] = 2'b00;
        applyStimulus(rAddr, 20, -1);
        repeat (60) @(negedge clk);
        checkOutput("stallBeats16", 32'(cmdBeats), 32'd16);
        checkOutput("stallCycLow", 32'(wb_cyc_o), 32'd0);
        checkOutput("stallFifoValid", 32'(dout_valid), 32'd1);
        drainLeft = 3;
        readyMode = 3;
        repeat (40) @(negedge clk);
        checkOutput("stallAfter3Pops", 32'(cmdBeats), 32'd16);
        checkOutput("stallAfter3PopsCyc", 32'(wb_cyc_o), 32'd0);
        drainLeft = 1;
        waitDone(0);
        checkOutput("totalBeats20", 32'(cmdBeats), 32'd20);
        drainAll();

        // Bus error on the second beat.
        $display("[TB] bus error on beat 2 of len=4");
        applyStimulus(32'h0000_3000, 4, 1);
        waitDone(1);
        checkOutput("errBeatsIssued", 32'(cmdBeats), 32'd2);
        drainAll();

        // Zero-length command: no bus activity, done two cycles later.
        $display("[TB] len=0 command");
        applyStimulus(32'h0000_2000, 0, -1);
        waitDone(0);
        checkOutput("len0DoneLatency", 32'(lastDoneCycle - acceptCycle), 32'd2);
        checkOutput("len0NoCyc", 32'(cycSeen), 32'd0);

        // Address wrap-around at the top of the space.
        $display("[TB] address wrap from 0xFFFFFFF8");
        applyStimulus(32'hFFFF_FFF8, 4, -1);
        waitDone(0);
        drainAll();

        // Randomized commands with wait states, consumer jitter, stray
        // ack/err while idle and occasional injected errors.
        $display("[TB] randomized commands");
        zeroWait = 0;
        noiseOn  = 1;
        for (int n = 0; n < 12; n++) begin
            rAddr = $urandom;
            rAddr[1:0] = 2'b00;
            rLen = $urandom_range(0, 40);
            rErr = -1;
            if (rLen > 0 && $urandom_range(0, 3) == 0) rErr = $urandom_range(0, rLen - 1);
            readyMode = 2;
            applyStimulus(rAddr, rLen, rErr);
            waitDone(rErr >= 0);
            if (n % 2 == 1) drainAll();
        end
        drainAll();
        noiseOn = 0;

        // Reset in the middle of a burst.
        $display("[TB] reset mid-burst");
        readyMode = 1;
        applyStimulus(32'h0000_8000, 40, -1);
        seen = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (cmdBeats >= 5 && wb_cyc_o) begin
                seen = 1;
                break;
            end
        end
        if (!seen) reportFail("midBurstReach", "burst never reached beat 5, required within 500 cycles");
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midResetCyc", 32'(wb_cyc_o), 32'd0);
        checkOutput("midResetStatus", {28'd0, dout_valid, busy, done, err}, 32'd0);
        busQ.delete();
        dataQ.delete();
        pendingDrop = 0;
        beatsAtReset = cmdBeats;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("cmdReadyAfterMidReset", 32'(cmd_ready), 32'd1);
        repeat (3) @(negedge clk);
        checkOutput("noBeatsAfterReset", 32'(cmdBeats), 32'(beatsAtReset));
        checkOutput("idleAfterReset", {30'd0, wb_cyc_o, dout_valid}, 32'd0);

        // Recovery after reset.
        applyStimulus(32'h0000_0040, 5, -1);
        waitDone(0);
        drainAll();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
